multiport_regfile: RTL and testbench

- Parametrised successor to the 4x4 single-port register block: WIDTH x DEPTH register file with one write port and two independent registered read ports.
- Adds per-entry valid tracking, same-cycle write-to-read bypass, and a multi-cycle bulk-clear sequencer with a busy flag.
- Sits between user-facing switch/button logic and display/LED drivers; also serves as the general scratch register store for later datapath blocks.

---
 rtl/regfile_pkg.sv | 30 +++
 rtl/regfile_read_port.sv | 114 +++++++++++
 rtl/multiport_regfile.sv | 181 ++++++++++++++++++
 tb/tb_multiport_regfile.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared types and helpers for the multiport register file.
//               It holds the sequencer state encoding, the default geometry
//               and the even-parity helper.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  // The parity helper takes a fixed-width operand. Callers zero-extend their
  // data into it, and the extra zero bits leave the XOR reduction unchanged.
  localparam int PAR_MAX_W = 256;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Even-parity bit: set when the data has an odd number of ones, so that
  // data plus parity always holds an even count.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// ============================================================================
// Module      : regfile_read_port
// Description : One registered read port of the register file. The output
//               register is loaded only when the port is enabled. The module
//               applies the range check, forces zero data while a clear is
//               running, and selects same-cycle write data on an address hit.
// Options     : REGFILE_PARITY_EN adds the stored-parity input and the
//               registered parity-error output.
// Ports       : clk, rst (sync, active-low)
//               rd_en_i, rd_addr_i         - port enable / address
//               clearing_i                 - clear sequence active
//               ent_data_i, ent_valid_i    - addressed entry contents
//               wr_en_i, wr_addr_i, wr_data_i - qualified write this cycle
//               rd_data_o, rd_valid_o      - registered results
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEF_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  input  logic             clearing_i,
  input  logic [WIDTH-1:0] ent_data_i,
  input  logic             ent_valid_i,
`ifdef REGFILE_PARITY_EN
  input  logic             ent_par_i,
  input  logic             wr_par_i,
  output logic             rd_perr_o,
`endif
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_valid_o
);

  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  logic             w_in_range;
  logic             w_bypass;
  logic [WIDTH-1:0] rd_data_d;
  logic             rd_valid_d;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;

  assign w_in_range = ({1'b0, rd_addr_i} < C_DEPTH);
  // wr_en_i is already qualified (in range, idle), so a plain address match
  // is enough to forward the incoming data.
  assign w_bypass   = wr_en_i && (wr_addr_i == rd_addr_i);

`ifdef REGFILE_PARITY_EN
  logic                 w_spar;
  logic [PAR_MAX_W-1:0] w_ext;
  logic                 rd_perr_d;
  logic                 rd_perr_q;
`endif

  always_comb begin
    rd_data_d  = ent_data_i;
    rd_valid_d = ent_valid_i;
`ifdef REGFILE_PARITY_EN
    w_spar     = ent_par_i;
`endif
    if (clearing_i || !w_in_range) begin
      rd_data_d  = '0;
      rd_valid_d = 1'b0;
`ifdef REGFILE_PARITY_EN
      w_spar     = 1'b0;
`endif
    end else if (w_bypass) begin
      rd_data_d  = wr_data_i;
      rd_valid_d = 1'b1;
`ifdef REGFILE_PARITY_EN
      w_spar     = wr_par_i;
`endif
    end
`ifdef REGFILE_PARITY_EN
    w_ext            = '0;
    w_ext[WIDTH-1:0] = rd_data_d;
    rd_perr_d        = rd_valid_d && (even_parity(w_ext) != w_spar);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
`ifdef REGFILE_PARITY_EN
      rd_perr_q  <= 1'b0;
`endif
    end else if (rd_en_i) begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
`ifdef REGFILE_PARITY_EN
      rd_perr_q  <= rd_perr_d;
`endif
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
`ifdef REGFILE_PARITY_EN
  assign rd_perr_o  = rd_perr_q;
`endif

endmodule
`default_nettype wire

// File: rtl/multiport_regfile.sv
`default_nettype none
// ============================================================================
// Module      : multiport_regfile
// Description : WIDTH x DEPTH register file with one write port, two
//               registered read ports, per-entry valid bits, write-to-read
//               bypass and a DEPTH-cycle bulk-clear sequencer.
// Options     : REGFILE_PARITY_EN stores an even-parity bit per entry. It
//               also adds the parity_inject input and the read_out_perr0/1
//               outputs.
// Ports       : clk, rst (sync, active-low)
//               write_enable, write_in_address, write_in_data
//               read_enable[1:0], read_out_address0/1
//               read_out_data0/1, read_out_valid0/1
//               clear_req, busy
// Revision    : 1.0 - initial release
// ============================================================================
module multiport_regfile
  import regfile_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write_enable,
  input  logic [AW-1:0]    write_in_address,
  input  logic [WIDTH-1:0] write_in_data,
  input  logic [1:0]       read_enable,
  input  logic [AW-1:0]    read_out_address0,
  input  logic [AW-1:0]    read_out_address1,
  output logic [WIDTH-1:0] read_out_data0,
  output logic [WIDTH-1:0] read_out_data1,
  output logic             read_out_valid0,
  output logic             read_out_valid1,
`ifdef REGFILE_PARITY_EN
  input  logic             parity_inject,
  output logic             read_out_perr0,
  output logic             read_out_perr1,
`endif
  input  logic             clear_req,
  output logic             busy
);

  localparam logic [AW:0]   C_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] C_LAST  = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q   [DEPTH];
  logic             valid_q [DEPTH];
  state_t           state_q;
  logic [AW-1:0]    cnt_q;
  logic             busy_q;

  logic             w_clearing;
  logic             w_wr_en;
  logic [AW-1:0]    w_idx0;
  logic [AW-1:0]    w_idx1;

  assign w_clearing = (state_q == ST_CLEAR);
  // A clear request in the same cycle takes precedence over the write.
  assign w_wr_en    = write_enable && !clear_req && !w_clearing &&
                      ({1'b0, write_in_address} < C_DEPTH);

  // Out-of-range read addresses are folded onto entry 0 only to keep the
  // array lookup legal. The read port discards that value.
  assign w_idx0 = ({1'b0, read_out_address0} < C_DEPTH) ? read_out_address0 : '0;
  assign w_idx1 = ({1'b0, read_out_address1} < C_DEPTH) ? read_out_address1 : '0;

`ifdef REGFILE_PARITY_EN
  logic                 par_q [DEPTH];
  logic [PAR_MAX_W-1:0] w_wr_ext;
  logic                 w_wr_par;

  always_comb begin
    w_wr_ext            = '0;
    w_wr_ext[WIDTH-1:0] = write_in_data;
    w_wr_par            = even_parity(w_wr_ext) ^ parity_inject;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i]   <= '0;
        valid_q[i] <= 1'b0;
`ifdef REGFILE_PARITY_EN
        par_q[i]   <= 1'b0;
`endif
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clear_req) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else if (w_wr_en) begin
            mem_q[write_in_address]   <= write_in_data;
            valid_q[write_in_address] <= 1'b1;
`ifdef REGFILE_PARITY_EN
            par_q[write_in_address]   <= w_wr_par;
`endif
          end
        end
        ST_CLEAR: begin
          mem_q[cnt_q]   <= '0;
          valid_q[cnt_q] <= 1'b0;
`ifdef REGFILE_PARITY_EN
          par_q[cnt_q]   <= 1'b0;
`endif
          if (cnt_q == C_LAST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + AW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;

  regfile_read_port #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_rd_port0 (
    .clk         (clk),
    .rst         (rst),
    .rd_en_i     (read_enable[0]),
    .rd_addr_i   (read_out_address0),
    .clearing_i  (w_clearing),
    .ent_data_i  (mem_q[w_idx0]),
    .ent_valid_i (valid_q[w_idx0]),
`ifdef REGFILE_PARITY_EN
    .ent_par_i   (par_q[w_idx0]),
    .wr_par_i    (w_wr_par),
    .rd_perr_o   (read_out_perr0),
`endif
    .wr_en_i     (w_wr_en),
    .wr_addr_i   (write_in_address),
    .wr_data_i   (write_in_data),
    .rd_data_o   (read_out_data0),
    .rd_valid_o  (read_out_valid0)
  );

  regfile_read_port #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_rd_port1 (
    .clk         (clk),
    .rst         (rst),
    .rd_en_i     (read_enable[1]),
    .rd_addr_i   (read_out_address1),
    .clearing_i  (w_clearing),
    .ent_data_i  (mem_q[w_idx1]),
    .ent_valid_i (valid_q[w_idx1]),
`ifdef REGFILE_PARITY_EN
    .ent_par_i   (par_q[w_idx1]),
    .wr_par_i    (w_wr_par),
    .rd_perr_o   (read_out_perr1),
`endif
    .wr_en_i     (w_wr_en),
    .wr_addr_i   (write_in_address),
    .wr_data_i   (write_in_data),
    .rd_data_o   (read_out_data1),
    .rd_valid_o  (read_out_valid1)
  );

endmodule
`default_nettype wire

// File: tb/tb_multiport_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_multiport_regfile
// Description : Self-checking bench for multiport_regfile. A vector table
//               drives a 8x4 instance and checks it through a queue of
//               expected results. Hand-written sequences cover the 8x5
//               instance (out-of-range addresses, clear length) and, when
//               REGFILE_PARITY_EN is defined, parity injection.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multiport_regfile;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // 8x4 instance
  logic       rst, we, clr;
  logic [1:0] wa, re, ra0, ra1;
  logic [7:0] wd;
  logic [7:0] d0, d1;
  logic       v0, v1, bsy;
`ifdef REGFILE_PARITY_EN
  logic       inj, perr0, perr1;
`endif

  // 8x5 instance
  logic       b_we, b_clr;
  logic [2:0] b_wa, b_ra0, b_ra1;
  logic [1:0] b_re;
  logic [7:0] b_wd, b_d0, b_d1;
  logic       b_v0, b_v1, b_bsy;
`ifdef REGFILE_PARITY_EN
  logic       b_perr0, b_perr1;
`endif

  multiport_regfile #(.WIDTH(8), .DEPTH(4)) u_dut (
    .clk               (clk),
    .rst               (rst),
    .write_enable      (we),
    .write_in_address  (wa),
    .write_in_data     (wd),
    .read_enable       (re),
    .read_out_address0 (ra0),
    .read_out_address1 (ra1),
    .read_out_data0    (d0),
    .read_out_data1    (d1),
    .read_out_valid0   (v0),
    .read_out_valid1   (v1),
`ifdef REGFILE_PARITY_EN
    .parity_inject     (inj),
    .read_out_perr0    (perr0),
    .read_out_perr1    (perr1),
`endif
    .clear_req         (clr),
    .busy              (bsy)
  );

  multiport_regfile #(.WIDTH(8), .DEPTH(5)) u_dut5 (
    .clk               (clk),
    .rst               (rst),
    .write_enable      (b_we),
    .write_in_address  (b_wa),
    .write_in_data     (b_wd),
    .read_enable       (b_re),
    .read_out_address0 (b_ra0),
    .read_out_address1 (b_ra1),
    .read_out_data0    (b_d0),
    .read_out_data1    (b_d1),
    .read_out_valid0   (b_v0),
    .read_out_valid1   (b_v1),
`ifdef REGFILE_PARITY_EN
    .parity_inject     (1'b0),
    .read_out_perr0    (b_perr0),
    .read_out_perr1    (b_perr1),
`endif
    .clear_req         (b_clr),
    .busy              (b_bsy)
  );

  typedef struct {
    logic       rst;
    logic       we;
    logic [1:0] wa;
    logic [7:0] wd;
    logic [1:0] re;
    logic [1:0] ra0;
    logic [1:0] ra1;
    logic       clr;
    logic [7:0] d0;
    logic       v0;
    logic [7:0] d1;
    logic       v1;
    logic       bsy;
  } vec_t;

  typedef struct {
    int         idx;
    logic [7:0] d0;
    logic       v0;
    logic [7:0] d1;
    logic       v1;
    logic       bsy;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic vec_t mk(logic r, logic w, logic [1:0] a, logic [7:0] d,
                              logic [1:0] e, logic [1:0] a0, logic [1:0] a1,
                              logic c, logic [7:0] x0, logic y0,
                              logic [7:0] x1, logic y1, logic b);
    vec_t v;
    v.rst = r;  v.we = w;   v.wa = a;   v.wd = d;   v.re = e;
    v.ra0 = a0; v.ra1 = a1; v.clr = c;
    v.d0 = x0;  v.v0 = y0;  v.d1 = x1;  v.v1 = y1;  v.bsy = b;
    return v;
  endfunction

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    else
      n_pass++;
  endtask

  task automatic idle_inputs();
    we = 1'b0; wa = '0; wd = '0; re = '0; ra0 = '0; ra1 = '0; clr = 1'b0;
`ifdef REGFILE_PARITY_EN
    inj = 1'b0;
`endif
    b_we = 1'b0; b_wa = '0; b_wd = '0; b_re = '0; b_ra0 = '0; b_ra1 = '0;
    b_clr = 1'b0;
  endtask

  // Drive one vector, queue its expectation, and check after the edge.
  task automatic apply(vec_t v, int idx);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst = v.rst; we = v.we; wa = v.wa; wd = v.wd; re = v.re;
    ra0 = v.ra0; ra1 = v.ra1; clr = v.clr;
    e.idx = idx; e.d0 = v.d0; e.v0 = v.v0; e.d1 = v.d1; e.v1 = v.v1;
    e.bsy = v.bsy;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    chk($sformatf("v%0d.data0", got.idx), d0, got.d0);
    chk($sformatf("v%0d.valid0", got.idx), 8'(v0), 8'(got.v0));
    chk($sformatf("v%0d.data1", got.idx), d1, got.d1);
    chk($sformatf("v%0d.valid1", got.idx), 8'(v1), 8'(got.v1));
    chk($sformatf("v%0d.busy", got.idx), 8'(bsy), 8'(got.bsy));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[28];

  initial begin
    int busy_cnt;
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);

    //            rst we wa wd     re ra0 ra1 clr  d0     v0 d1     v1 busy
    tbl[0]  = mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
    tbl[1]  = mk(1, 0, 0, 8'h00, 3, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0);
    tbl[2]  = mk(1, 1, 1, 8'hA5, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
    tbl[3]  = mk(1, 0, 0, 8'h00, 3, 1, 0, 0, 8'hA5, 1, 8'h00, 0, 0);
    tbl[4]  = mk(1, 1, 2, 8'h3C, 3, 2, 2, 0, 8'h3C, 1, 8'h3C, 1, 0);
    tbl[5]  = mk(1, 0, 0, 8'h00, 1, 1, 0, 0, 8'hA5, 1, 8'h3C, 1, 0);
    tbl[6]  = mk(1, 0, 0, 8'h00, 2, 0, 1, 0, 8'hA5, 1, 8'hA5, 1, 0);
    tbl[7]  = mk(1, 1, 0, 8'h11, 0, 0, 0, 0, 8'hA5, 1, 8'hA5, 1, 0);
    tbl[8]  = mk(1, 1, 1, 8'h22, 0, 0, 0, 0, 8'hA5, 1, 8'hA5, 1, 0);
    tbl[9]  = mk(1, 1, 2, 8'h33, 0, 0, 0, 0, 8'hA5, 1, 8'hA5, 1, 0);
    tbl[10] = mk(1, 1, 3, 8'h44, 0, 0, 0, 0, 8'hA5, 1, 8'hA5, 1, 0);
    tbl[11] = mk(1, 0, 0, 8'h00, 3, 3, 0, 0, 8'h44, 1, 8'h11, 1, 0);
    tbl[12] = mk(1, 1, 0, 8'hEE, 0, 0, 0, 1, 8'h44, 1, 8'h11, 1, 1);
    tbl[13] = mk(1, 1, 3, 8'hFF, 3, 3, 3, 0, 8'h00, 0, 8'h00, 0, 1);
    tbl[14] = mk(1, 1, 0, 8'hFF, 0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 1);
    tbl[15] = mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 1);
    tbl[16] = mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
    tbl[17] = mk(1, 0, 0, 8'h00, 3, 3, 0, 0, 8'h00, 0, 8'h00, 0, 0);
    tbl[18] = mk(1, 0, 0, 8'h00, 3, 1, 2, 0, 8'h00, 0, 8'h00, 0, 0);
    tbl[19] = mk(1, 1, 2, 8'h5A, 1, 2, 0, 0, 8'h5A, 1, 8'h00, 0, 0);
    tbl[20] = mk(1, 1, 1, 8'h77, 0, 0, 0, 0, 8'h5A, 1, 8'h00, 0, 0);
    tbl[21] = mk(1, 1, 3, 8'h88, 0, 0, 0, 0, 8'h5A, 1, 8'h00, 0, 0);
    tbl[22] = mk(1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h5A, 1, 8'h00, 0, 1);
    tbl[23] = mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h5A, 1, 8'h00, 0, 1);
    tbl[24] = mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
    tbl[25] = mk(1, 0, 0, 8'h00, 3, 1, 3, 0, 8'h00, 0, 8'h00, 0, 0);
    tbl[26] = mk(1, 1, 1, 8'h66, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
    tbl[27] = mk(1, 0, 0, 8'h00, 1, 1, 0, 0, 8'h66, 1, 8'h00, 0, 0);

    for (int i = 0; i < 28; i++) apply(tbl[i], i);

    // ---- 8x5 instance: out-of-range addresses and a 5-cycle clear ----
    @(negedge clk);
    idle_inputs();
    b_we = 1'b1; b_wa = 3'd5; b_wd = 8'h99;
    @(negedge clk);
    b_wa = 3'd4; b_wd = 8'h12;
    @(negedge clk);
    b_we = 1'b0; b_re = 2'b11; b_ra0 = 3'd4; b_ra1 = 3'd5;
    tick();
    chk("d5.rd4.data", b_d0, 8'h12);
    chk("d5.rd4.valid", 8'(b_v0), 8'h01);
    chk("d5.rd5.data", b_d1, 8'h00);
    chk("d5.rd5.valid", 8'(b_v1), 8'h00);
    @(negedge clk);
    b_we = 1'b1; b_wa = 3'd6; b_wd = 8'h55; b_ra0 = 3'd6; b_ra1 = 3'd4;
    tick();
    chk("d5.byp_oor.data", b_d0, 8'h00);
    chk("d5.byp_oor.valid", 8'(b_v0), 8'h00);
    chk("d5.rd4b.data", b_d1, 8'h12);
    @(negedge clk);
    b_we = 1'b0; b_re = 2'b00; b_clr = 1'b1;
    @(negedge clk);
    b_clr = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 20 && b_bsy; k++) begin
      busy_cnt++;
      @(negedge clk);
    end
    chk("d5.clear_len", 8'(busy_cnt), 8'd5);
    b_re = 2'b11; b_ra0 = 3'd4; b_ra1 = 3'd0;
    tick();
    chk("d5.post_clr.valid0", 8'(b_v0), 8'h00);
    chk("d5.post_clr.data0", b_d0, 8'h00);

`ifdef REGFILE_PARITY_EN
    // ---- parity injection on the 8x4 instance ----
    @(negedge clk);
    idle_inputs();
    we = 1'b1; wa = 2'd3; wd = 8'h0F; inj = 1'b1;
    @(negedge clk);
    idle_inputs();
    re = 2'b01; ra0 = 2'd3;
    tick();
    chk("par.inj.data0", d0, 8'h0F);
    chk("par.inj.perr0", 8'(perr0), 8'h01);
    @(negedge clk);
    idle_inputs();
    we = 1'b1; wa = 2'd3; wd = 8'h0F;
    @(negedge clk);
    idle_inputs();
    re = 2'b01; ra0 = 2'd3;
    tick();
    chk("par.clean.perr0", 8'(perr0), 8'h00);
    @(negedge clk);
    we = 1'b1; wa = 2'd2; wd = 8'h01; inj = 1'b1;
    re = 2'b11; ra0 = 2'd2; ra1 = 2'd2;
    tick();
    chk("par.byp_inj.perr0", 8'(perr0), 8'h01);
    chk("par.byp_inj.perr1", 8'(perr1), 8'h01);
    @(negedge clk);
    we = 1'b1; wa = 2'd1; wd = 8'h07; inj = 1'b0;
    re = 2'b11; ra0 = 2'd1; ra1 = 2'd2;
    tick();
    chk("par.byp_clean.perr0", 8'(perr0), 8'h00);
    chk("par.stored_inj.perr1", 8'(perr1), 8'h01);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
